// File: rtl/uart_mmio_master.sv
// -----------------------------------------------------------------------------
// uart_mmio_master
//
// Hardware bus initiator for the UART memory-mapped port. A start request
// copies a block of words from a source region (typically the RX buffer) to a
// destination region (typically the TX buffer), one word at a time, XORing a
// key into the low byte of each word in flight. This gives the UART an
// echo/loopback and self-test path that needs no firmware.
//
// Parameters:
//   RD_LAT  cycles between driving a read address and r_data being valid
//           (0 = combinational read)
//   CNT_W   width of the word-count input
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_i        synchronous, active-high reset
//   start_i      one-cycle transfer request, sampled only in IDLE
//   src_base_i   byte address of the first source word
//   dst_base_i   byte address of the first destination word
//   count_i      number of words to copy (0 = empty transfer)
//   xor_key_i    XORed into bits [7:0] of every written word
//   address_o    bus address to the UART
//   w_data_o     bus write data (holds its last value outside a write)
//   we_o         bus write enable, one cycle per word
//   r_data_i     bus read data from the UART
//   busy_o       high while a transfer is in progress
//   done_o       one-cycle pulse when a transfer completes
// -----------------------------------------------------------------------------
module uart_mmio_master #(
    parameter int RD_LAT = 0,
    parameter int CNT_W  = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [15:0]      src_base_i,
    input  logic [15:0]      dst_base_i,
    input  logic [CNT_W-1:0] count_i,
    input  logic [7:0]       xor_key_i,
    output logic [15:0]      address_o,
    output logic [31:0]      w_data_o,
    output logic             we_o,
    input  logic [31:0]      r_data_i,
    output logic             busy_o,
    output logic             done_o
);

    // The wait counter runs 0..RD_LAT inside RD; keep it at least one bit wide
    // so the RD_LAT=0 build still has a legal vector.
    localparam int WAIT_W = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_LAT);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [CNT_W-1:0]  IDX_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_FIN  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  idx_q,   idx_d;
    logic [WAIT_W-1:0] wait_q,  wait_d;
    logic [15:0]       src_q,   src_d;
    logic [15:0]       dst_q,   dst_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [7:0]        key_q,   key_d;
    logic [31:0]       held_q,  held_d;   // word captured on the last RD cycle
    logic [31:0]       wlast_q, wlast_d;  // last word written, driven outside WR

    logic [15:0] word_offset;
    logic [31:0] wr_word;

    // Byte offset of the current word; 16-bit arithmetic gives the required
    // modulo wrap past 16'hFFFF and leaves the base's low two bits untouched.
    assign word_offset = 16'(idx_q) << 2;
    assign wr_word     = {held_q[31:8], held_q[7:0] ^ key_q};

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d   = state_q;
        idx_d     = idx_q;
        wait_d    = wait_q;
        src_d     = src_q;
        dst_d     = dst_q;
        cnt_d     = cnt_q;
        key_d     = key_q;
        held_d    = held_q;
        wlast_d   = wlast_q;
        address_o = 16'h0000;
        w_data_o  = wlast_q;
        we_o      = 1'b0;
        busy_o    = 1'b0;
        done_o    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    // Snapshot the request so later input changes cannot
                    // disturb the running transfer.
                    src_d  = src_base_i;
                    dst_d  = dst_base_i;
                    cnt_d  = count_i;
                    key_d  = xor_key_i;
                    idx_d  = '0;
                    wait_d = '0;
                    state_d = (count_i != '0) ? S_RD : S_FIN;
                end
            end

            S_RD: begin
                busy_o    = 1'b1;
                address_o = src_q + word_offset;
                if (wait_q == WAIT_LAST) begin
                    held_d  = r_data_i;
                    wait_d  = '0;
                    state_d = S_WR;
                end else begin
                    wait_d = wait_q + WAIT_ONE;
                end
            end

            S_WR: begin
                busy_o    = 1'b1;
                we_o      = 1'b1;
                address_o = dst_q + word_offset;
                w_data_o  = wr_word;
                wlast_d   = wr_word;
                if (idx_q + IDX_ONE == cnt_q) begin
                    state_d = S_FIN;
                end else begin
                    idx_d   = idx_q + IDX_ONE;
                    state_d = S_RD;
                end
            end

            S_FIN: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments here so every register samples the
        // pre-edge value of every other register, regardless of statement order.
        if (rst_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            wait_q  <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            key_q   <= '0;
            held_q  <= '0;
            wlast_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            held_q  <= held_d;
            wlast_q <= wlast_d;
        end
    end

endmodule

// File: tb/tb_uart_mmio_master.sv
// -----------------------------------------------------------------------------
// tb_uart_mmio_master
//
// Directed bench for uart_mmio_master. Two instances share clock, reset and
// request inputs: dut0 with a combinational read (RD_LAT=0) and dut1 with a
// two-cycle read latency (RD_LAT=2). Each has its own UART memory model.
// Every test walks a cycle table of hand-computed expected bus outputs.
// -----------------------------------------------------------------------------
module tb_uart_mmio_master;

    typedef struct packed {
        logic [15:0] addr;
        logic        we;
        logic        busy;
        logic        done;
        logic [31:0] wdata;
    } obs_t;

    logic        clk;
    logic        rst;
    logic        start0, start1;
    logic [15:0] src_base, dst_base;
    logic [3:0]  count;
    logic [7:0]  xor_key;

    logic [15:0] address0, address1;
    logic [31:0] w_data0, w_data1;
    logic        we0, we1, busy0, busy1, done0, done1;
    logic [31:0] r_data0, r_data1;
    logic [15:0] a1_d1, a1_d2;

    int n_cmp = 0;
    int n_err = 0;

    uart_mmio_master #(.RD_LAT(0), .CNT_W(4)) dut0 (
        .clk_i(clk), .rst_i(rst), .start_i(start0),
        .src_base_i(src_base), .dst_base_i(dst_base), .count_i(count),
        .xor_key_i(xor_key), .address_o(address0), .w_data_o(w_data0),
        .we_o(we0), .r_data_i(r_data0), .busy_o(busy0), .done_o(done0)
    );

    uart_mmio_master #(.RD_LAT(2), .CNT_W(4)) dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start1),
        .src_base_i(src_base), .dst_base_i(dst_base), .count_i(count),
        .xor_key_i(xor_key), .address_o(address1), .w_data_o(w_data1),
        .we_o(we1), .r_data_i(r_data1), .busy_o(busy1), .done_o(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // UART memory contents seen by the reads.
    function automatic logic [31:0] mem_model(input logic [15:0] a);
        case (a)
            16'h0000: return 32'h0000_00A5;
            16'h0004: return 32'h0000_003C;
            16'h0100: return 32'h1234_5678;
            16'hFFFC: return 32'hDEAD_BE11;
            default:  return {16'hC0DE, a};
        endcase
    endfunction

    always_comb r_data0 = mem_model(address0);

    // Two-cycle read pipeline for dut1.
    always @(posedge clk) begin
        a1_d1 <= address1;
        a1_d2 <= a1_d1;
    end
    always_comb r_data1 = mem_model(a1_d2);

    function automatic obs_t sample0();
        return '{address0, we0, busy0, done0, w_data0};
    endfunction

    function automatic obs_t sample1();
        return '{address1, we1, busy1, done1, w_data1};
    endfunction

    // Advance one clock; sample and drive 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [15:0] s, input logic [15:0] d,
                           input logic [3:0] n, input logic [7:0] k);
        src_base = s;
        dst_base = d;
        count    = n;
        xor_key  = k;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        obs_t got;
        rst    = 1'b1;
        start0 = 1'b1;
        start1 = 1'b1;
        set_req(16'h0000, 16'h0020, 4'd2, 8'h00);
        tick();
        tick();
        got = sample0();
        n_cmp++;
        if (got !== obs_t'(0)) begin
            n_err++;
            $display("FAIL reset dut0: got %h expected %h", got, obs_t'(0));
        end
        got = sample1();
        n_cmp++;
        if (got !== obs_t'(0)) begin
            n_err++;
            $display("FAIL reset dut1: got %h expected %h", got, obs_t'(0));
        end
        rst    = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        tick();
        got = sample0();
        n_cmp++;
        if (got !== obs_t'(0)) begin
            n_err++;
            $display("FAIL reset_idle dut0: got %h expected %h", got, obs_t'(0));
        end
        got = sample1();
        n_cmp++;
        if (got !== obs_t'(0)) begin
            n_err++;
            $display("FAIL reset_idle dut1: got %h expected %h", got, obs_t'(0));
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_basic_copy();
        obs_t exp[6];
        obs_t got;
        exp[0] = '{16'h0000, 1'b0, 1'b1, 1'b0, 32'h0000_0000};
        exp[1] = '{16'h0020, 1'b1, 1'b1, 1'b0, 32'h0000_00A5};
        exp[2] = '{16'h0004, 1'b0, 1'b1, 1'b0, 32'h0000_00A5};
        exp[3] = '{16'h0024, 1'b1, 1'b1, 1'b0, 32'h0000_003C};
        exp[4] = '{16'h0000, 1'b0, 1'b0, 1'b1, 32'h0000_003C};
        exp[5] = '{16'h0000, 1'b0, 1'b0, 1'b0, 32'h0000_003C};
        set_req(16'h0000, 16'h0020, 4'd2, 8'h00);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        // Changing the request mid-transfer must not matter.
        set_req(16'h0F00, 16'h0E00, 4'd7, 8'h55);
        for (int c = 0; c < 6; c++) begin
            got = sample0();
            n_cmp++;
            if (got !== exp[c]) begin
                n_err++;
                $display("FAIL basic_copy cycle %0d: got %h expected %h", c + 1, got, exp[c]);
            end
            tick();
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_latency_key();
        obs_t exp[6];
        obs_t got;
        exp[0] = '{16'h0100, 1'b0, 1'b1, 1'b0, 32'h0000_0000};
        exp[1] = '{16'h0100, 1'b0, 1'b1, 1'b0, 32'h0000_0000};
        exp[2] = '{16'h0100, 1'b0, 1'b1, 1'b0, 32'h0000_0000};
        exp[3] = '{16'h0040, 1'b1, 1'b1, 1'b0, 32'h1234_5687};
        exp[4] = '{16'h0000, 1'b0, 1'b0, 1'b1, 32'h1234_5687};
        exp[5] = '{16'h0000, 1'b0, 1'b0, 1'b0, 32'h1234_5687};
        set_req(16'h0100, 16'h0040, 4'd1, 8'hFF);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int c = 0; c < 6; c++) begin
            got = sample1();
            n_cmp++;
            if (got !== exp[c]) begin
                n_err++;
                $display("FAIL latency_key cycle %0d: got %h expected %h", c + 1, got, exp[c]);
            end
            tick();
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_count_zero();
        obs_t exp[3];
        obs_t got;
        exp[0] = '{16'h0000, 1'b0, 1'b0, 1'b1, 32'h0000_003C};
        exp[1] = '{16'h0000, 1'b0, 1'b0, 1'b0, 32'h0000_003C};
        exp[2] = '{16'h0000, 1'b0, 1'b0, 1'b0, 32'h0000_003C};
        set_req(16'h0000, 16'h0020, 4'd0, 8'h00);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            got = sample0();
            n_cmp++;
            if (got !== exp[c]) begin
                n_err++;
                $display("FAIL count_zero cycle %0d: got %h expected %h", c + 1, got, exp[c]);
            end
            tick();
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_start_while_busy();
        obs_t exp[7];
        obs_t got;
        int   done_seen;
        exp[0] = '{16'h0000, 1'b0, 1'b1, 1'b0, 32'h0000_003C};
        exp[1] = '{16'h0080, 1'b1, 1'b1, 1'b0, 32'h0000_00AA};
        exp[2] = '{16'h0004, 1'b0, 1'b1, 1'b0, 32'h0000_00AA};
        exp[3] = '{16'h0084, 1'b1, 1'b1, 1'b0, 32'h0000_0033};
        exp[4] = '{16'h0000, 1'b0, 1'b0, 1'b1, 32'h0000_0033};
        exp[5] = '{16'h0000, 1'b0, 1'b0, 1'b0, 32'h0000_0033};
        exp[6] = '{16'h0000, 1'b0, 1'b0, 1'b0, 32'h0000_0033};
        done_seen = 0;
        set_req(16'h0000, 16'h0080, 4'd2, 8'h0F);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int c = 0; c < 7; c++) begin
            got = sample0();
            done_seen += int'(got.done);
            n_cmp++;
            if (got !== exp[c]) begin
                n_err++;
                $display("FAIL start_while_busy cycle %0d: got %h expected %h", c + 1, got, exp[c]);
            end
            // Competing requests during WR (cycle 2) and FIN (cycle 5).
            if (c == 1 || c == 4) begin
                set_req(16'h0100, 16'h0200, 4'd1, 8'h00);
                start0 = 1'b1;
            end else begin
                start0 = 1'b0;
            end
            tick();
        end
        n_cmp++;
        if (done_seen !== 1) begin
            n_err++;
            $display("FAIL start_while_busy done_count: got %0d expected 1", done_seen);
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset_mid_transfer();
        obs_t exp[9];
        obs_t rexp[3];
        obs_t got;
        exp[0] = '{16'h0000, 1'b0, 1'b1, 1'b0, 32'h0000_0033};
        exp[1] = '{16'h0020, 1'b1, 1'b1, 1'b0, 32'h0000_00A5};
        exp[2] = '{16'h0004, 1'b0, 1'b1, 1'b0, 32'h0000_00A5};
        exp[3] = '{16'h0024, 1'b1, 1'b1, 1'b0, 32'h0000_003C};
        for (int c = 4; c < 9; c++) exp[c] = obs_t'(0);
        set_req(16'h0000, 16'h0020, 4'd3, 8'h00);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int c = 0; c < 9; c++) begin
            got = sample0();
            n_cmp++;
            if (got !== exp[c]) begin
                n_err++;
                $display("FAIL reset_mid cycle %0d: got %h expected %h", c + 1, got, exp[c]);
            end
            rst = (c == 3);  // reset sampled at the end of word-1 WR
            tick();
        end
        rexp[0] = '{16'h0004, 1'b0, 1'b1, 1'b0, 32'h0000_0000};
        rexp[1] = '{16'h0030, 1'b1, 1'b1, 1'b0, 32'h0000_003C};
        rexp[2] = '{16'h0000, 1'b0, 1'b0, 1'b1, 32'h0000_003C};
        set_req(16'h0004, 16'h0030, 4'd1, 8'h00);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            got = sample0();
            n_cmp++;
            if (got !== rexp[c]) begin
                n_err++;
                $display("FAIL restart cycle %0d: got %h expected %h", c + 1, got, rexp[c]);
            end
            tick();
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_wrap();
        obs_t exp[5];
        obs_t got;
        exp[0] = '{16'hFFFC, 1'b0, 1'b1, 1'b0, 32'h0000_003C};
        exp[1] = '{16'hFFFC, 1'b1, 1'b1, 1'b0, 32'hDEAD_BE10};
        exp[2] = '{16'h0000, 1'b0, 1'b1, 1'b0, 32'hDEAD_BE10};
        exp[3] = '{16'h0000, 1'b1, 1'b1, 1'b0, 32'h0000_00A4};
        exp[4] = '{16'h0000, 1'b0, 1'b0, 1'b1, 32'h0000_00A4};
        set_req(16'hFFFC, 16'hFFFC, 4'd2, 8'h01);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int c = 0; c < 5; c++) begin
            got = sample0();
            n_cmp++;
            if (got !== exp[c]) begin
                n_err++;
                $display("FAIL wrap cycle %0d: got %h expected %h", c + 1, got, exp[c]);
            end
            tick();
        end
    endtask

    // -------------------------------------------------------------------------
    initial begin
        rst    = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        set_req(16'h0000, 16'h0000, 4'd0, 8'h00);
        test_reset();
        test_basic_copy();
        test_latency_key();
        test_count_zero();
        test_start_while_busy();
        test_reset_mid_transfer();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
